// File: rtl/branch_predict_ctrl.sv
// Branch direction/target predictor: direct-mapped BTB with 2-bit counters,
// EX-stage table update, misprediction flush/redirect and saturating statistics.
module branch_predict_ctrl #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  if_pc,
  output logic             if_pred_taken,
  output logic [XLEN-1:0]  if_pred_target,
  input  logic             ex_valid,
  input  logic             ex_stall,
  input  logic             ex_is_branch,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  ex_target,
  input  logic             ex_taken,
  input  logic             ex_pred_taken,
  input  logic [XLEN-1:0]  ex_pred_target,
  output logic             flush,
  output logic [XLEN-1:0]  redirect_pc,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = XLEN - IDX_W - 2;

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_d    [ENTRIES];
  logic [XLEN-1:0]    target_q [ENTRIES];
  logic [XLEN-1:0]    target_d [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];
  logic [1:0]         ctr_d    [ENTRIES];
  logic [CNT_W-1:0]   branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0]   mispred_cnt_q, mispred_cnt_d;

  logic [IDX_W-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0] if_tag, ex_tag;
  logic             if_hit, ex_hit;
  logic [XLEN-1:0]  if_pc_plus4, ex_pc_plus4;
  logic             upd, mispredict;

  assign if_idx      = if_pc[IDX_W+1:2];
  assign if_tag      = if_pc[XLEN-1:IDX_W+2];
  assign ex_idx      = ex_pc[IDX_W+1:2];
  assign ex_tag      = ex_pc[XLEN-1:IDX_W+2];
  assign if_pc_plus4 = if_pc + XLEN'(4);
  assign ex_pc_plus4 = ex_pc + XLEN'(4);

  // IF lookup reads pre-edge table contents; no bypass from the EX write
  always_comb begin
    if_hit         = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    if_pred_taken  = !rst && if_hit && ctr_q[if_idx][1];
    if_pred_target = if_pred_taken ? target_q[if_idx] : if_pc_plus4;
  end

  // Misprediction detection and pipeline redirect
  always_comb begin
    upd        = ex_valid && !ex_stall && !rst;
    ex_hit     = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    mispredict = 1'b0;
    if (ex_is_branch) begin
      mispredict = (ex_taken != ex_pred_taken) ||
                   (ex_taken && ex_pred_taken && (ex_pred_target != ex_target));
    end else begin
      mispredict = ex_pred_taken;
    end
    mispredict  = mispredict && upd;
    flush       = mispredict;
    redirect_pc = '0;
    if (mispredict) begin
      redirect_pc = (ex_is_branch && ex_taken) ? ex_target : ex_pc_plus4;
    end
  end

  // Table and statistics next state
  always_comb begin
    valid_d       = valid_q;
    tag_d         = tag_q;
    target_d      = target_q;
    ctr_d         = ctr_q;
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (upd) begin
      if (ex_is_branch) begin
        if (ex_hit) begin
          target_d[ex_idx] = ex_target;
          if (ex_taken) begin
            if (ctr_q[ex_idx] != 2'b11) ctr_d[ex_idx] = ctr_q[ex_idx] + 2'd1;
          end else begin
            if (ctr_q[ex_idx] != 2'b00) ctr_d[ex_idx] = ctr_q[ex_idx] - 2'd1;
          end
        end else if (ex_taken) begin
          valid_d[ex_idx]  = 1'b1;
          tag_d[ex_idx]    = ex_tag;
          target_d[ex_idx] = ex_target;
          ctr_d[ex_idx]    = 2'b10;
        end
      end else if (ex_pred_taken) begin
        // Stale or aliased entry predicted a non-branch as taken
        valid_d[ex_idx] = 1'b0;
      end
      if (ex_is_branch && (branch_cnt_q != '1)) begin
        branch_cnt_d = branch_cnt_q + CNT_W'(1);
      end
      if (mispredict && (mispred_cnt_q != '1)) begin
        mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q       <= '0;
      tag_q         <= '{default: '0};
      target_q      <= '{default: '0};
      ctr_q         <= '{default: 2'b01};
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      valid_q       <= valid_d;
      tag_q         <= tag_d;
      target_q      <= target_d;
      ctr_q         <= ctr_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Directed-vector bench for branch_predict_ctrl: table of per-cycle vectors
// plus hand sequences for mid-operation reset and counter saturation.
module tb_branch_predict_ctrl;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [XLEN-1:0]  if_pc;
  logic             if_pred_taken;
  logic [XLEN-1:0]  if_pred_target;
  logic             ex_valid, ex_stall, ex_is_branch, ex_taken, ex_pred_taken;
  logic [XLEN-1:0]  ex_pc, ex_target, ex_pred_target;
  logic             flush;
  logic [XLEN-1:0]  redirect_pc;
  logic [CNT_W-1:0] branch_cnt, mispred_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_predict_ctrl #(.XLEN(XLEN), .ENTRIES(16), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .if_pc          (if_pc),
    .if_pred_taken  (if_pred_taken),
    .if_pred_target (if_pred_target),
    .ex_valid       (ex_valid),
    .ex_stall       (ex_stall),
    .ex_is_branch   (ex_is_branch),
    .ex_pc          (ex_pc),
    .ex_target      (ex_target),
    .ex_taken       (ex_taken),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .flush          (flush),
    .redirect_pc    (redirect_pc),
    .branch_cnt     (branch_cnt),
    .mispred_cnt    (mispred_cnt)
  );

  typedef struct {
    logic        v, s, b;
    logic [31:0] pc, tgt;
    logic        tk, ptk;
    logic [31:0] ptgt, ifpc;
    logic        e_flush;
    logic [31:0] e_redir;
    logic        e_ptk;
    logic [31:0] e_ptgt;
    logic [15:0] e_bc, e_mc;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic s, input logic b, input logic [31:0] pc,
                       input logic [31:0] tgt, input logic tk, input logic ptk,
                       input logic [31:0] ptgt, input logic [31:0] ifpc);
    ex_valid       = v;
    ex_stall       = s;
    ex_is_branch   = b;
    ex_pc          = pc;
    ex_target      = tgt;
    ex_taken       = tk;
    ex_pred_taken  = ptk;
    ex_pred_target = ptgt;
    if_pc          = ifpc;
  endtask

  task automatic idle(input logic [31:0] ifpc);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, ifpc);
  endtask

  initial begin
    // v s b  pc        tgt       tk ptk ptgt      ifpc      flush redir     ptk ptgt      bc      mc
    vecs.push_back('{0,0,0, 32'h000, 32'h000, 0,0, 32'h000, 32'h100, 0, 32'h000, 0, 32'h104, 16'd0, 16'd0});
    vecs.push_back('{1,0,1, 32'h100, 32'h080, 1,0, 32'h104, 32'h100, 1, 32'h080, 0, 32'h104, 16'd0, 16'd0});
    vecs.push_back('{0,0,0, 32'h000, 32'h000, 0,0, 32'h000, 32'h100, 0, 32'h000, 1, 32'h080, 16'd1, 16'd1});
    vecs.push_back('{1,0,1, 32'h100, 32'h080, 1,1, 32'h080, 32'h100, 0, 32'h000, 1, 32'h080, 16'd1, 16'd1});
    vecs.push_back('{1,0,1, 32'h100, 32'h080, 1,1, 32'h080, 32'h100, 0, 32'h000, 1, 32'h080, 16'd2, 16'd1});
    vecs.push_back('{1,0,1, 32'h100, 32'h080, 1,1, 32'h080, 32'h100, 0, 32'h000, 1, 32'h080, 16'd3, 16'd1});
    vecs.push_back('{1,0,1, 32'h100, 32'h080, 0,1, 32'h080, 32'h100, 1, 32'h104, 1, 32'h080, 16'd4, 16'd1});
    vecs.push_back('{0,0,0, 32'h000, 32'h000, 0,0, 32'h000, 32'h100, 0, 32'h000, 1, 32'h080, 16'd5, 16'd2});
    vecs.push_back('{1,0,1, 32'h300, 32'h3C0, 0,0, 32'h304, 32'h300, 0, 32'h000, 0, 32'h304, 16'd5, 16'd2});
    vecs.push_back('{1,0,1, 32'h100, 32'h090, 1,1, 32'h080, 32'h300, 1, 32'h090, 0, 32'h304, 16'd6, 16'd2});
    vecs.push_back('{0,0,0, 32'h000, 32'h000, 0,0, 32'h000, 32'h100, 0, 32'h000, 1, 32'h090, 16'd7, 16'd3});
    vecs.push_back('{1,1,1, 32'h100, 32'h090, 0,1, 32'h090, 32'h100, 0, 32'h000, 1, 32'h090, 16'd7, 16'd3});
    vecs.push_back('{1,0,1, 32'h100, 32'h090, 0,1, 32'h090, 32'h100, 1, 32'h104, 1, 32'h090, 16'd7, 16'd3});
    vecs.push_back('{1,0,1, 32'h140, 32'h200, 1,0, 32'h144, 32'h140, 1, 32'h200, 0, 32'h144, 16'd8, 16'd4});
    vecs.push_back('{0,0,0, 32'h000, 32'h000, 0,0, 32'h000, 32'h140, 0, 32'h000, 1, 32'h200, 16'd9, 16'd5});
    vecs.push_back('{0,0,0, 32'h000, 32'h000, 0,0, 32'h000, 32'h100, 0, 32'h000, 0, 32'h104, 16'd9, 16'd5});
    vecs.push_back('{1,0,0, 32'h100, 32'h000, 0,1, 32'h080, 32'h140, 1, 32'h104, 1, 32'h200, 16'd9, 16'd5});
    vecs.push_back('{0,0,0, 32'h000, 32'h000, 0,0, 32'h000, 32'h140, 0, 32'h000, 0, 32'h144, 16'd9, 16'd6});
    vecs.push_back('{1,0,0, 32'hFFFFFFFC, 32'h0, 0,1, 32'h0, 32'hFFFFFFFC, 1, 32'h000, 0, 32'h000, 16'd9, 16'd6});
    vecs.push_back('{0,0,0, 32'h100, 32'h000, 0,1, 32'h080, 32'h140, 0, 32'h000, 0, 32'h144, 16'd9, 16'd7});

    rst = 1'b1;
    idle(32'h100);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].s, vecs[i].b, vecs[i].pc, vecs[i].tgt, vecs[i].tk,
            vecs[i].ptk, vecs[i].ptgt, vecs[i].ifpc);
      #1;
      chk($sformatf("v%0d_flush", i),     32'(flush),          32'(vecs[i].e_flush));
      chk($sformatf("v%0d_redirect", i),  redirect_pc,         vecs[i].e_redir);
      chk($sformatf("v%0d_pred_taken", i), 32'(if_pred_taken), 32'(vecs[i].e_ptk));
      chk($sformatf("v%0d_pred_target", i), if_pred_target,    vecs[i].e_ptgt);
      chk($sformatf("v%0d_branch_cnt", i), 32'(branch_cnt),    32'(vecs[i].e_bc));
      chk($sformatf("v%0d_mispred_cnt", i), 32'(mispred_cnt),  32'(vecs[i].e_mc));
      @(negedge clk);
    end

    // Reset in the middle of a mispredicting update
    drive(1'b1, 1'b0, 1'b1, 32'h1C0, 32'h020, 1'b1, 1'b0, 32'h1C4, 32'h1C0);
    @(negedge clk);
    idle(32'h1C0);
    #1;
    chk("rst_pre_alloc_pred", 32'(if_pred_taken), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 32'h180, 32'h040, 1'b1, 1'b0, 32'h184, 32'h1C0);
    #1;
    chk("rst_flush",      32'(flush),       32'd0);
    chk("rst_redirect",   redirect_pc,      32'h0);
    chk("rst_pred_taken", 32'(if_pred_taken), 32'd0);
    chk("rst_pred_target", if_pred_target,  32'h1C4);
    @(negedge clk);
    rst = 1'b0;
    idle(32'h1C0);
    #1;
    chk("post_rst_1c0_pred", 32'(if_pred_taken), 32'd0);
    chk("post_rst_bc",       32'(branch_cnt),     32'd0);
    chk("post_rst_mc",       32'(mispred_cnt),    32'd0);
    if_pc = 32'h180;
    #1;
    chk("post_rst_180_pred", 32'(if_pred_taken), 32'd0);
    chk("post_rst_180_tgt",  if_pred_target,     32'h184);

    // Statistics saturation: always-mispredicting taken branch
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 32'h200, 32'h040, 1'b1, 1'b0, 32'h204, 32'h100);
    repeat (65534) @(negedge clk);
    idle(32'h100);
    #1;
    chk("sat_bc_pre", 32'(branch_cnt),  32'h0000FFFE);
    chk("sat_mc_pre", 32'(mispred_cnt), 32'h0000FFFE);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 32'h200, 32'h040, 1'b1, 1'b0, 32'h204, 32'h100);
    repeat (2) @(negedge clk);
    idle(32'h100);
    #1;
    chk("sat_bc_full", 32'(branch_cnt),  32'h0000FFFF);
    chk("sat_mc_full", 32'(mispred_cnt), 32'h0000FFFF);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 32'h200, 32'h040, 1'b1, 1'b0, 32'h204, 32'h100);
    @(negedge clk);
    idle(32'h100);
    #1;
    chk("sat_bc_hold", 32'(branch_cnt),  32'h0000FFFF);
    chk("sat_mc_hold", 32'(mispred_cnt), 32'h0000FFFF);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("sat_rst_bc", 32'(branch_cnt),  32'd0);
    chk("sat_rst_mc", 32'(mispred_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
